// File: rtl/string_char_streamer_if.sv
// Bundle of handshake, FIFO and status signals between the string char
// streamer and its surroundings. The streamer uses the slave view; the
// control layer / FIFO / sink side uses the master view.
interface string_char_streamer_if;
    logic        start;
    logic [1:0]  mode;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        fifo_rd;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] length;

    modport slave (
        input  start,
        input  mode,
        input  fifo_empty,
        input  fifo_rdata,
        input  out_ready,
        output fifo_rd,
        output out_char,
        output out_valid,
        output busy,
        output done,
        output err,
        output length
    );

    modport master (
        output start,
        output mode,
        output fifo_empty,
        output fifo_rdata,
        output out_ready,
        input  fifo_rd,
        input  out_char,
        input  out_valid,
        input  busy,
        input  done,
        input  err,
        input  length
    );
endinterface

// File: rtl/string_char_streamer.sv
// Pops packed 4-character words from the string FIFO and streams them one
// byte per cycle on a valid/ready output, with optional case conversion.
// Stops on the NUL terminator or when MAX_LEN characters have been sent.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; length/err hold result of last string
// FETCH | pop next word as soon as the FIFO is not empty
// EMIT  | present word[31:24]; shift on each accepted character
// DONE  | one-cycle done pulse, then back to IDLE
module string_char_streamer #(
    parameter int unsigned MAX_LEN = 1024
) (
    input  logic clk,
    input  logic reset,
    string_char_streamer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]  MODE_PASS   = 2'd0;
    localparam logic [1:0]  MODE_UPPER  = 2'd1;
    localparam logic [1:0]  MODE_LOWER  = 2'd2;
    localparam logic [1:0]  MODE_TOGGLE = 2'd3;

    // Compared against the 17-bit incremented length so MAX_LEN = 65535
    // cannot wrap the comparison.
    localparam logic [16:0] MAX_LEN_W   = 17'(MAX_LEN);

    state_t      state_q, state_d;
    logic [31:0] word_q,  word_d;
    logic [1:0]  idx_q,   idx_d;
    logic [1:0]  mode_q,  mode_d;
    logic [15:0] len_q,   len_d;
    logic        err_q,   err_d;

    logic [7:0]  cur_byte;
    logic [16:0] len_inc;

    logic        fifo_rd_c;
    logic        out_valid_c;
    logic [7:0]  out_char_c;
    logic        busy_c;
    logic        done_c;

    function automatic logic [7:0] convert(input logic [7:0] c, input logic [1:0] m);
        logic is_lower;
        logic is_upper;
        logic [7:0] r;
        is_lower = (c >= 8'h61) && (c <= 8'h7A);
        is_upper = (c >= 8'h41) && (c <= 8'h5A);
        r = c;
        case (m)
            MODE_UPPER: begin
                if (is_lower) r = c - 8'h20;
            end
            MODE_LOWER: begin
                if (is_upper) r = c + 8'h20;
            end
            MODE_TOGGLE: begin
                if (is_lower)      r = c - 8'h20;
                else if (is_upper) r = c + 8'h20;
            end
            MODE_PASS: r = c;
            default:   r = c;
        endcase
        return r;
    endfunction

    assign cur_byte = word_q[31:24];
    assign len_inc  = {1'b0, len_q} + 17'd1;

    // State and datapath registers; reset drops everything back to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= 32'h0;
            idx_q   <= 2'd0;
            mode_q  <= MODE_PASS;
            len_q   <= 16'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath update and all combinational outputs.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        len_d       = len_q;
        err_d       = err_q;
        fifo_rd_c   = 1'b0;
        out_valid_c = 1'b0;
        out_char_c  = 8'h00;
        busy_c      = 1'b0;
        done_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d   = 16'h0;
                    err_d   = 1'b0;
                    mode_d  = bus.mode;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                busy_c = 1'b1;
                if (!bus.fifo_empty) begin
                    fifo_rd_c = 1'b1;
                    word_d    = bus.fifo_rdata;
                    idx_d     = 2'd0;
                    state_d   = S_EMIT;
                end
            end

            S_EMIT: begin
                busy_c = 1'b1;
                if (cur_byte == 8'h00) begin
                    // Terminator: the rest of this word is discarded.
                    state_d = S_DONE;
                end else begin
                    out_valid_c = 1'b1;
                    out_char_c  = convert(cur_byte, mode_q);
                    if (bus.out_ready) begin
                        len_d  = len_inc[15:0];
                        word_d = {word_q[23:0], 8'h00};
                        idx_d  = idx_q + 2'd1;
                        // Length limit wins over the word-boundary fetch so a
                        // word beyond the limit is never popped.
                        if (len_inc == MAX_LEN_W) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else if (idx_q == 2'd3) begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end

            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.fifo_rd   = fifo_rd_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_char  = out_char_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.err       = err_q;
    assign bus.length    = len_q;

endmodule

// File: tb/tb_string_char_streamer.sv
// Directed bench for string_char_streamer with a FIFO model, an expected
// character queue and a monitor that checks every accepted character.
module tb_string_char_streamer;

    logic clk;
    logic reset;

    string_char_streamer_if ifc ();

    string_char_streamer #(.MAX_LEN(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_checks;
    int n_fail;
    int pops;

    logic [31:0] fq[$];
    logic [7:0]  exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every character accepted by the sink must be the next expected one.
    always @(negedge clk) begin
        if (!reset && ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL char_unexpected: got %0h, expected no character", ifc.out_char);
            end else begin
                check("char", {24'h0, ifc.out_char}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // First-word-fall-through FIFO model.
    initial begin
        logic rd;
        logic was_empty;
        ifc.fifo_empty = 1'b1;
        ifc.fifo_rdata = 32'h0;
        forever begin
            @(negedge clk);
            rd        = ifc.fifo_rd;
            was_empty = ifc.fifo_empty;
            @(posedge clk);
            if (rd && !reset) begin
                if (was_empty || fq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_empty: got fifo_rd 1, expected 0 while empty");
                end else begin
                    void'(fq.pop_front());
                    pops++;
                end
            end
            #1;
            ifc.fifo_empty = (fq.size() == 0);
            ifc.fifo_rdata = (fq.size() != 0) ? fq[0] : 32'h0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic do_start(input logic [1:0] m);
        tick();
        ifc.start = 1'b1;
        ifc.mode  = m;
        tick();
        ifc.start = 1'b0;
        ifc.mode  = 2'd0;
    endtask

    task automatic finish_string(input string tag, input int exp_len, input logic exp_err,
                                 input int exp_pops);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ifc.done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
        if (seen) begin
            check({tag, "_length"}, {16'h0, ifc.length}, exp_len);
            check({tag, "_err"}, {31'h0, ifc.err}, {31'h0, exp_err});
            check({tag, "_pops"}, pops, exp_pops);
            check({tag, "_chars_left"}, exp_q.size(), 0);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, {31'h0, ifc.done}, 32'h0);
            check({tag, "_busy_after"}, {31'h0, ifc.busy}, 32'h0);
        end
    endtask

    task automatic wait_char(input logic [7:0] c, output logic found);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (ifc.out_valid && ifc.out_char == c) found = 1'b1;
        end
        check("wait_char_found", {31'h0, found}, 32'h1);
    endtask

    task automatic prep();
        fq.delete();
        exp_q.delete();
        pops = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic starved;
        n_checks      = 0;
        n_fail        = 0;
        pops          = 0;
        reset         = 1'b1;
        ifc.start     = 1'b0;
        ifc.mode      = 2'd0;
        ifc.out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_fifo_rd", {31'h0, ifc.fifo_rd}, 32'h0);
        check("rst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
        check("rst_out_char", {24'h0, ifc.out_char}, 32'h0);
        check("rst_busy", {31'h0, ifc.busy}, 32'h0);
        check("rst_done", {31'h0, ifc.done}, 32'h0);
        check("rst_err", {31'h0, ifc.err}, 32'h0);
        check("rst_length", {16'h0, ifc.length}, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Plain pass-through across two words
        prep();
        fq.push_back(32'h61626364);
        fq.push_back(32'h31320000);
        expect_str("abcd12");
        do_start(2'd0);
        finish_string("pass", 6, 1'b0, 2);

        // Case conversion modes
        prep();
        fq.push_back(32'h61427A7B);
        fq.push_back(32'h00000000);
        expect_str("ABZ{");
        do_start(2'd1);
        finish_string("upper", 4, 1'b0, 2);

        prep();
        fq.push_back(32'h61427A7B);
        fq.push_back(32'h00000000);
        expect_str("abz{");
        do_start(2'd2);
        finish_string("lower", 4, 1'b0, 2);

        prep();
        fq.push_back(32'h61427A7B);
        fq.push_back(32'h00000000);
        expect_str("AbZ{");
        do_start(2'd3);
        finish_string("toggle", 4, 1'b0, 2);

        // Back-pressure while 'c' is presented
        prep();
        fq.push_back(32'h61626364);
        fq.push_back(32'h00000000);
        expect_str("abcd");
        do_start(2'd0);
        wait_char(8'h62, found);
        tick();
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", {31'h0, ifc.out_valid}, 32'h1);
            check("stall_char", {24'h0, ifc.out_char}, 32'h63);
        end
        tick();
        ifc.out_ready = 1'b1;
        @(negedge clk);
        check("stall_char_last", {24'h0, ifc.out_char}, 32'h63);
        finish_string("stall", 4, 1'b0, 2);

        // FIFO runs dry between words
        prep();
        fq.push_back(32'h61626364);
        expect_str("abcdefg");
        do_start(2'd0);
        starved = 1'b0;
        for (int i = 0; i < 100 && !starved; i++) begin
            @(negedge clk);
            if (ifc.busy && !ifc.out_valid && pops == 1) starved = 1'b1;
        end
        check("gap_starved", {31'h0, starved}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("gap_fifo_rd", {31'h0, ifc.fifo_rd}, 32'h0);
            check("gap_out_valid", {31'h0, ifc.out_valid}, 32'h0);
            @(negedge clk);
        end
        fq.push_back(32'h65666700);
        finish_string("gap", 7, 1'b0, 2);

        // Length limit with no terminator: third word stays in the FIFO
        prep();
        fq.push_back(32'h61626364);
        fq.push_back(32'h65666768);
        fq.push_back(32'h696A6B6C);
        expect_str("abcdefgh");
        do_start(2'd0);
        finish_string("limit", 8, 1'b1, 2);
        check("limit_words_left", fq.size(), 1);
        check("limit_head_word", fq[0], 32'h696A6B6C);

        // Limit reached exactly at a word boundary before a NUL word
        prep();
        fq.push_back(32'h61626364);
        fq.push_back(32'h65666768);
        fq.push_back(32'h00000000);
        expect_str("ABCDEFGH");
        do_start(2'd1);
        finish_string("limit_nul", 8, 1'b1, 2);
        check("limit_nul_words_left", fq.size(), 1);

        // New start clears err
        prep();
        fq.push_back(32'h78790000);
        expect_str("xy");
        do_start(2'd0);
        finish_string("err_clear", 2, 1'b0, 1);

        // Reset during the second character
        prep();
        fq.push_back(32'h61626364);
        fq.push_back(32'h00000000);
        expect_str("abcd");
        do_start(2'd0);
        wait_char(8'h62, found);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_fifo_rd", {31'h0, ifc.fifo_rd}, 32'h0);
        check("mid_rst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
        check("mid_rst_out_char", {24'h0, ifc.out_char}, 32'h0);
        check("mid_rst_busy", {31'h0, ifc.busy}, 32'h0);
        check("mid_rst_done", {31'h0, ifc.done}, 32'h0);
        check("mid_rst_length", {16'h0, ifc.length}, 32'h0);
        check("mid_rst_pops", pops, 1);
        tick();
        reset = 1'b0;
        prep();
        fq.push_back(32'h78790000);
        expect_str("xy");
        do_start(2'd0);
        finish_string("after_rst", 2, 1'b0, 1);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/string_char_streamer.md
# string_char_streamer

Downstream consumer of the string word FIFO. Pops packed 32-bit words (four ASCII characters, first character in bits [31:24]) and emits them one byte per cycle on a valid/ready stream. Applies an optional case conversion and stops at the NUL terminator. Reports string length, completion and a length-limit error to the control/Avalon layer.

## Interface
- MAX_LEN, 1024: maximum characters emitted per string before forced termination (1..65535)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin one string; sampled in IDLE only
- mode  in  2  0 pass, 1 upper, 2 lower, 3 toggle case; latched on accepted start
- fifo_empty  in  1  FIFO has no word
- fifo_rdata  in  32  FIFO head word (first-word-fall-through, valid when !fifo_empty)
- fifo_rd  out  1  pop head word this cycle
- out_char  out  8  converted character
- out_valid  out  1  out_char valid
- out_ready  in  1  sink accepts out_char
- busy  out  1  high in FETCH/EMIT
- done  out  1  one-cycle completion pulse
- err  out  1  last string hit MAX_LEN without NUL; held until next start
- length  out  16  characters emitted for last/current string; held until next start

## Operation
- States: IDLE, FETCH, EMIT, DONE. Registers: word shift reg (32), byte index (2), mode latch (2), length (16), err.
- IDLE: start=1 -> length=0, err=0, latch mode, go FETCH. start while busy is ignored.
- FETCH: fifo_rd = !fifo_empty (combinational, only in FETCH). On pop: word <= fifo_rdata, index=0, go EMIT. Empty: wait, no pop.
- EMIT: current byte = word[31:24].
  - Byte == 0x00: go DONE. No output, remaining bytes discarded, no further pops.
  - Else out_valid=1, out_char=convert(byte). On out_ready: length+1, word <<= 8, index+1.
    - If length+1 == MAX_LEN: err=1, go DONE.
    - Else if index was 3: go FETCH.
    - Else stay.
- DONE: done=1 for one cycle, go IDLE.
- Conversion: upper maps 0x61–0x7A by −0x20. Lower maps 0x41–0x5A by +0x20. Toggle does both. Every other byte passes unchanged.
- MAX_LEN termination takes priority over word-boundary fetch. A word after the limit is never popped.

## Timing
- Reset values: fifo_rd=0, out_char=0x00, out_valid=0, busy=0, done=0, err=0, length=0, state IDLE.
- start accepted in IDLE -> FETCH next cycle. Pop and EMIT entry take one cycle. First char is valid the cycle after the pop.
- Full throughput: 4 chars per 5 cycles (1 fetch + 4 emit).
- out_char and out_valid hold stable while out_valid && !out_ready. No char is dropped or duplicated.
- NUL seen in EMIT -> DONE next cycle -> done pulse -> IDLE the following cycle. A new start is accepted in IDLE.
- Reset mid-string: immediate return to reset values. A word already popped is lost. The FIFO is not touched further.
- length updates on the same edge as each accepted char.

## Test plan
- FIFO "abcd", "12\0\0", mode 0 -> a,b,c,d,1,2 emitted, 2 pops, length=6, done pulse, err=0.
- FIFO "aBz{", "\0\0\0\0", mode 1 -> A,B,Z,{; mode 2 -> a,b,z,{; mode 3 -> A,b,Z,{; length=4 each.
- out_ready low 3 cycles while 'c' of "abcd" is presented -> out_char=0x63 held 4 cycles, then d, no repeat.
- fifo_empty high 5 cycles between words 1 and 2 -> fifo_rd=0, out_valid=0 during the gap, then stream resumes with the correct order.
- MAX_LEN=8, FIFO "abcd", "efgh", "ijkl" (no NUL) -> 8 chars, err=1, length=8, done, "ijkl" not popped.
- Reset asserted during EMIT of second char -> all outputs at reset values next sample. A new start then processes "xy\0\0" -> length=2.
